// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and defaults for the sequential multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int ITER          = DEFAULT_WIDTH;

endpackage

// File: rtl/cond_negate.sv
// rtl/cond_negate.sv - conditional two's-complement negate: y = (x ^ {N{s}}) + s
module cond_negate #(
    parameter int N = 32
) (
    input  logic [N-1:0] x,
    input  logic         s,
    output logic [N-1:0] y
);

    assign y = (x ^ {N{s}}) + N'(s);

endmodule

// File: rtl/mult_unit_seq.sv
// rtl/mult_unit_seq.sv - sequential shift-add multiplier producing HI/LO for mult/multu
module mult_unit_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sum;

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];

    cond_negate #(.N(WIDTH)) u_neg_a (
        .x (a),
        .s (a_neg),
        .y (a_mag)
    );

    cond_negate #(.N(WIDTH)) u_neg_b (
        .x (b),
        .s (b_neg),
        .y (b_mag)
    );

    cond_negate #(.N(2*WIDTH)) u_neg_prod (
        .x (acc),
        .s (neg),
        .y (prod)
    );

    // The carry out of the upper-half add becomes the new MSB after the shift.
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, ma};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            ma    <= '0;
            mb    <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ma    <= a_mag;
                        mb    <= b_mag;
                        neg   <= a_neg ^ b_neg;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == LAST_CNT) begin
                        state <= FIX;
                    end else begin
                        if (mb[0]) begin
                            acc <= {sum, acc[WIDTH-1:1]};
                        end else begin
                            acc <= {1'b0, acc[2*WIDTH-1:1]};
                        end
                        mb  <= mb >> 1;
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    {hi, lo} <= prod;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit_seq.sv
// tb/tb_mult_unit_seq.sv - scoreboard bench for mult_unit_seq against an arithmetic reference
module tb_mult_unit_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;
    int done_count = 0;
    logic [63:0] exp_q[$];

    mult_unit_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] x, input logic [31:0] y);
        longint      sp;
        logic [63:0] ux;
        logic [63:0] uy;
        if (s) begin
            sp = longint'($signed(x)) * longint'($signed(y));
            return sp;
        end
        ux = {32'd0, x};
        uy = {32'd0, y};
        return ux * uy;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    check("product", {hi, lo}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input bit s, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        is_signed = s;
        a         = x;
        b         = y;
        start     = 1'b1;
        exp_q.push_back(ref_mul(s, x, y));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits for done; optionally pulses a stray start at cycle inject (0 = none).
    task automatic wait_done(input int inject, output int latency, output int busy_cycles);
        latency     = -1;
        busy_cycles = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (cyc == inject) begin
                is_signed = 1'b0;
                a         = 32'd2;
                b         = 32'd2;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) begin
                latency = cyc - 1;
                break;
            end
        end
        start = 1'b0;
        if (latency < 0) check("timeout_done", 64'd0, 64'd1);
    endtask

    task automatic run_op(input bit s, input logic [31:0] x, input logic [31:0] y, input int inject);
        int lat;
        int bc;
        int d0;
        d0 = done_count;
        issue(s, x, y);
        wait_done(inject, lat, bc);
        check("latency", 64'(lat), 64'd34);
        check("busy_cycles", 64'(bc), 64'd34);
        @(negedge clk);
        check("done_single_pulse", 64'(done_count - d0), 64'd1);
    endtask

    initial begin
        logic [31:0] edge_vals [4];
        edge_vals[0] = 32'h0000_0000;
        edge_vals[1] = 32'h8000_0000;
        edge_vals[2] = 32'hFFFF_FFFF;
        edge_vals[3] = 32'h7FFF_FFFF;

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
        reset = 1'b0;

        run_op(1'b0, 32'd3, 32'd5, 0);
        check("multu_3x5_hold", {hi, lo}, 64'h0000_0000_0000_000F);
        run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 0);
        check("signed_min_sq", {hi, lo}, 64'h4000_0000_0000_0000);
        run_op(1'b1, 32'd0, 32'hFFFF_FFF9, 0);
        check("zero_neg", {hi, lo}, 64'd0);

        run_op(1'b0, 32'd7, 32'd9, 10);
        repeat (20) @(negedge clk);
        check("stray_start_hold", {hi, lo}, 64'd63);
        check("stray_start_busy", 64'(busy), 64'd0);

        // A start landing on the DONE cycle must be ignored.
        begin
            int d0;
            issue(1'b0, 32'd4, 32'd4);
            for (int cyc = 0; cyc < 100 && done !== 1'b1; cyc++) @(negedge clk);
            d0 = done_count;
            a = 32'd9; b = 32'd9; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            check("start_in_done_busy", 64'(busy), 64'd0);
            repeat (40) @(negedge clk);
            check("start_in_done_no_done", 64'(done_count - d0), 64'd0);
            check("start_in_done_hold", {hi, lo}, 64'd16);
        end

        for (int i = 0; i < 24; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = (i % 3 == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            y = (i % 4 == 1) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            run_op(1'($urandom_range(0, 1)), x, y, (i % 5 == 2) ? $urandom_range(2, 30) : 0);
        end

        // Reset mid-operation discards it.
        begin
            int d0;
            d0 = done_count;
            issue(1'b1, 32'd6, 32'hFFFF_FFF9);
            repeat (14) @(negedge clk);
            reset = 1'b1;
            #1;
            check("async_reset_clear", {30'd0, busy, done, hi, lo}, 64'd0);
            exp_q.delete();
            repeat (2) @(negedge clk);
            reset = 1'b0;
            repeat (40) @(negedge clk);
            check("reset_no_done", 64'(done_count - d0), 64'd0);
        end
        run_op(1'b0, 32'd6, 32'd7, 0);
        check("after_reset_6x7", {hi, lo}, 64'd42);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
